// File: rtl/pixel_seq_pkg.sv
// Shared constants and state encoding for the pixel frame sequencer.
package pixel_seq_pkg;

    localparam int DEF_ROWS  = 4;
    localparam int DEF_ROW_W = 2;
    localparam int DEF_ADC_W = 8;
    localparam int DEF_EXP_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ERASE   = 3'd1,
        ST_EXPOSE  = 3'd2,
        ST_SELECT  = 3'd3,
        ST_CONVERT = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

endpackage

// File: rtl/frame_sequencer_if.sv
// ADC handshake and result stream between the sequencer and its neighbours.
interface frame_sequencer_if #(
    parameter int ROW_W = pixel_seq_pkg::DEF_ROW_W,
    parameter int ADC_W = pixel_seq_pkg::DEF_ADC_W
);
    logic             adc_start;
    logic             adc_done;
    logic [ADC_W-1:0] adc_data;
    logic             out_valid;
    logic             out_ready;
    logic [ADC_W-1:0] out_data;
    logic [ROW_W-1:0] out_row;

    modport master (
        output adc_start,
        input  adc_done,
        input  adc_data,
        output out_valid,
        output out_data,
        output out_row,
        input  out_ready
    );

    modport slave (
        input  adc_start,
        output adc_done,
        output adc_data,
        input  out_valid,
        input  out_data,
        input  out_row,
        output out_ready
    );
endinterface

// File: rtl/exposure_timer.sv
// Loadable down-counter that stops at zero; used to time the exposure window.
module exposure_timer #(
    parameter int EXP_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [EXP_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);
    logic [EXP_W-1:0] count_q;
    logic [EXP_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);
endmodule

// File: rtl/frame_sequencer.sv
// Image-sensor frame sequencer: erase, expose, then read each row through a SAR ADC
// into a one-entry valid/ready result buffer.
module frame_sequencer
    import pixel_seq_pkg::*;
#(
    parameter int ROWS  = DEF_ROWS,
    parameter int ROW_W = DEF_ROW_W,
    parameter int ADC_W = DEF_ADC_W,
    parameter int EXP_W = DEF_EXP_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_start,
    input  logic [EXP_W-1:0] exp_time,
    output logic             erase,
    output logic             expose,
    output logic             row_en,
    output logic [ROW_W-1:0] row_sel,
    output logic             busy,
    output logic             frame_done,
    frame_sequencer_if.master bus
);
    state_e           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             first_q, first_d;
    logic             out_valid_q, out_valid_d;
    logic [ADC_W-1:0] out_data_q, out_data_d;
    logic [ROW_W-1:0] out_row_q, out_row_d;

    logic             adc_start;
    logic             tmr_load;
    logic             tmr_zero;
    logic [EXP_W-1:0] tmr_val;
    logic             buf_free;
    logic             handshake;
    logic             last_row;

    // Loading exp-1 makes the zero flag coincide with the final exposure cycle;
    // an exposure of 0 collapses to the same load as 1.
    assign tmr_load  = (state_q == ST_IDLE) && frame_start;
    assign tmr_val   = (exp_time == '0) ? '0 : exp_time - 1'b1;
    assign handshake = out_valid_q && bus.out_ready;
    assign buf_free  = !out_valid_q || bus.out_ready;
    assign last_row  = (row_q == ROW_W'(ROWS - 1));

    exposure_timer #(.EXP_W(EXP_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (state_q == ST_EXPOSE),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (frame_start) state_d = ST_ERASE;
            ST_ERASE:   state_d = ST_EXPOSE;
            ST_EXPOSE:  if (tmr_zero) state_d = ST_SELECT;
            ST_SELECT:  if (buf_free) state_d = ST_CONVERT;
            ST_CONVERT: if (bus.adc_done) state_d = last_row ? ST_DONE : ST_SELECT;
            ST_DONE:    if (!out_valid_q) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        erase      = (state_q == ST_ERASE);
        expose     = (state_q == ST_EXPOSE);
        row_en     = (state_q == ST_SELECT) || (state_q == ST_CONVERT);
        row_sel    = row_en ? row_q : '0;
        adc_start  = (state_q == ST_CONVERT) && first_q;
        busy       = (state_q != ST_IDLE);
        frame_done = (state_q == ST_DONE) && !out_valid_q;
    end

    // Row counter, start-pulse flag and the single result buffer.
    always_comb begin
        row_d       = row_q;
        first_d     = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_row_d   = out_row_q;
        if (handshake) begin
            out_valid_d = 1'b0;
        end
        if (tmr_load) begin
            row_d = '0;
        end
        if ((state_q == ST_SELECT) && buf_free) begin
            first_d = 1'b1;
        end
        if ((state_q == ST_CONVERT) && bus.adc_done) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.adc_data;
            out_row_d   = row_q;
            if (!last_row) begin
                row_d = row_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_q       <= '0;
            first_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
        end else begin
            row_q       <= row_d;
            first_q     <= first_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
        end
    end

    assign bus.adc_start = adc_start;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_row   = out_row_q;
endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench: ADC responder feeding a result scoreboard, a table of exposure
// vectors, and hand-written stall/ignore/abort sequences.
module tb_frame_sequencer;
    localparam int ROWS  = 4;
    localparam int ROW_W = 2;
    localparam int ADC_W = 8;
    localparam int EXP_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             frame_start = 1'b0;
    logic [EXP_W-1:0] exp_time = '0;
    logic             erase, expose, row_en, busy, frame_done;
    logic [ROW_W-1:0] row_sel;
    logic             spurious_req = 1'b0;

    frame_sequencer_if #(.ROW_W(ROW_W), .ADC_W(ADC_W)) bus ();

    frame_sequencer #(.ROWS(ROWS), .ROW_W(ROW_W), .ADC_W(ADC_W), .EXP_W(EXP_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .exp_time    (exp_time),
        .erase       (erase),
        .expose      (expose),
        .row_en      (row_en),
        .row_sel     (row_sel),
        .busy        (busy),
        .frame_done  (frame_done),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADC_W-1:0] data;
        logic [ROW_W-1:0] row;
    } result_t;

    typedef struct {
        int exp;
        int want_expose;
    } vec_t;

    result_t sb[$];
    int errors = 0;
    int checks = 0;
    int erase_tot = 0, expose_tot = 0, fd_tot = 0, start_tot = 0, res_tot = 0, viol = 0;
    int s_er, s_ex, s_fd, s_st, s_res;

    task automatic check_eq(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // ADC model (done 3 cycles after start, data = row*16+1) plus stream monitor.
    task automatic agent();
        int               cnt = 0;
        logic [ROW_W-1:0] pend_row = '0;
        bit               held = 0;
        logic [ADC_W-1:0] held_data = '0;
        logic [ROW_W-1:0] held_row = '0;
        result_t          exp_r;
        forever begin
            @(negedge clk);
            bus.adc_done = 1'b0;
            bus.adc_data = '0;
            if (!reset) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        bus.adc_done = 1'b1;
                        bus.adc_data = ADC_W'(int'(pend_row) * 16 + 1);
                        exp_r.data   = bus.adc_data;
                        exp_r.row    = pend_row;
                        sb.push_back(exp_r);
                    end
                end else if (spurious_req) begin
                    bus.adc_done = 1'b1;
                    bus.adc_data = 8'hEE;
                end
                if (bus.adc_start) begin
                    cnt      = 3;
                    pend_row = row_sel;
                end
            end
            #1;
            if (erase)         erase_tot++;
            if (expose)        expose_tot++;
            if (frame_done)    fd_tot++;
            if (bus.adc_start) start_tot++;
            if (erase && expose) viol++;
            if (row_en && (erase || expose || frame_done)) viol++;
            if (!reset) begin
                held = 0;
            end else begin
                if (held && (!bus.out_valid || bus.out_data != held_data || bus.out_row != held_row))
                    viol++;
                held      = bus.out_valid && !bus.out_ready;
                held_data = bus.out_data;
                held_row  = bus.out_row;
                if (bus.out_valid && bus.out_ready) begin
                    res_tot++;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got data %0d row %0d, required none",
                                 bus.out_data, bus.out_row);
                    end else begin
                        exp_r = sb.pop_front();
                        check_eq("out_data", int'(bus.out_data), int'(exp_r.data));
                        check_eq("out_row", int'(bus.out_row), int'(exp_r.row));
                    end
                end
            end
        end
    endtask

    task automatic snap();
        s_er = erase_tot; s_ex = expose_tot; s_fd = fd_tot; s_st = start_tot; s_res = res_tot;
    endtask

    task automatic start_frame(input int e);
        @(negedge clk);
        exp_time    = EXP_W'(e);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check_eq("erase_after_start", int'(erase), 1);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!frame_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!frame_done) check_eq({name, "_timeout"}, 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_frame(input string name, input int want_expose);
        $display("frame %s: erase=%0d expose=%0d results=%0d done=%0d starts=%0d", name,
                 erase_tot - s_er, expose_tot - s_ex, res_tot - s_res, fd_tot - s_fd, start_tot - s_st);
        check_eq({name, "_erase_cycles"}, erase_tot - s_er, 1);
        check_eq({name, "_expose_cycles"}, expose_tot - s_ex, want_expose);
        check_eq({name, "_results"}, res_tot - s_res, ROWS);
        check_eq({name, "_frame_done"}, fd_tot - s_fd, 1);
        check_eq({name, "_adc_starts"}, start_tot - s_st, ROWS);
        check_eq({name, "_sb_drained"}, sb.size(), 0);
    endtask

    initial begin
        vec_t vecs[5];
        int   n;
        int   bad_data, bad_sel, bad_start;
        vecs[0] = '{exp: 5,   want_expose: 5};
        vecs[1] = '{exp: 0,   want_expose: 1};
        vecs[2] = '{exp: 1,   want_expose: 1};
        vecs[3] = '{exp: 3,   want_expose: 3};
        vecs[4] = '{exp: 200, want_expose: 200};
        bus.out_ready = 1'b1;
        fork
            agent();
        join_none

        repeat (3) @(negedge clk);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_erase", int'(erase), 0);
        check_eq("rst_expose", int'(expose), 0);
        check_eq("rst_row_en", int'(row_en), 0);
        check_eq("rst_adc_start", int'(bus.adc_start), 0);
        check_eq("rst_out_valid", int'(bus.out_valid), 0);
        check_eq("rst_frame_done", int'(frame_done), 0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            snap();
            start_frame(vecs[i].exp);
            wait_done($sformatf("vec%0d", i));
            check_frame($sformatf("vec%0d", i), vecs[i].want_expose);
        end

        // Back-pressure after the first result, with an ignored restart and a stray adc_done.
        bus.out_ready = 1'b0;
        snap();
        start_frame(2);
        n = 0;
        while (!expose && n < 50) begin @(negedge clk); n++; end
        check_eq("stall_saw_expose", int'(expose), 1);
        exp_time    = 8'd9;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 500) begin @(negedge clk); n++; end
        check_eq("stall_first_data", int'(bus.out_data), 1);
        check_eq("stall_first_row", int'(bus.out_row), 0);
        bad_data = 0; bad_sel = 0; bad_start = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            spurious_req = (c == 5);
            if (!bus.out_valid || bus.out_data != 8'h01 || bus.out_row != 2'd0) bad_data++;
            if (!row_en || row_sel != 2'd1) bad_sel++;
            if (bus.adc_start) bad_start++;
        end
        spurious_req = 1'b0;
        check_eq("stall_data_hold", bad_data, 0);
        check_eq("stall_select_row1", bad_sel, 0);
        check_eq("stall_no_adc_start", bad_start, 0);
        bus.out_ready = 1'b1;
        wait_done("stall");
        check_frame("stall", 2);
        repeat (10) @(negedge clk);
        check_eq("ignored_start_busy", int'(busy), 0);
        check_eq("ignored_start_erase", erase_tot - s_er, 1);

        // Abort during the row-2 conversion.
        snap();
        start_frame(2);
        n = 0;
        while (!(bus.adc_start && row_sel == 2'd2) && n < 500) begin @(negedge clk); n++; end
        check_eq("abort_reached_row2", int'(row_sel), 2);
        reset = 1'b0;
        #1;
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_row_en", int'(row_en), 0);
        check_eq("abort_row_sel", int'(row_sel), 0);
        check_eq("abort_adc_start", int'(bus.adc_start), 0);
        check_eq("abort_out_valid", int'(bus.out_valid), 0);
        check_eq("abort_out_data", int'(bus.out_data), 0);
        check_eq("abort_out_row", int'(bus.out_row), 0);
        repeat (3) @(negedge clk);
        check_eq("abort_no_frame_done", fd_tot - s_fd, 0);
        check_eq("abort_results", res_tot - s_res, 2);
        check_eq("abort_sb_empty", sb.size(), 0);
        reset = 1'b1;
        snap();
        start_frame(5);
        wait_done("after_abort");
        check_frame("after_abort", 5);

        check_eq("invariant_violations", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of pixel rows read per frame (>=2).
REQ-002 SHALL have parameter ROW_W, default 2, row index width (2**ROW_W >= ROWS).
REQ-003 SHALL have parameter ADC_W, default 8, SAR result width.
REQ-004 SHALL have parameter EXP_W, default 8, exposure-time field width.
REQ-005 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port frame_start  in  1  request one frame; sampled only in IDLE.
REQ-008 SHALL have port exp_time  in  EXP_W  exposure length in cycles; latched at frame start.
REQ-009 SHALL have port erase  out  1  pixel erase strobe.
REQ-010 SHALL have port expose  out  1  pixel exposure window.
REQ-011 SHALL have ports row_en (out, 1, row decoder enable) and row_sel (out, ROW_W, selected row index).
REQ-012 SHALL have ports adc_start (out, 1, conversion start pulse), adc_done (in, 1, one-cycle completion pulse) and adc_data (in, ADC_W, result, valid with adc_done).
REQ-013 SHALL have ports out_valid (out, 1), out_ready (in, 1), out_data (out, ADC_W) and out_row (out, ROW_W), forming a valid/ready result stream.
REQ-014 SHALL have ports busy (out, 1, high whenever state != IDLE) and frame_done (out, 1, one-cycle end-of-frame pulse).

Function
REQ-015 SHALL implement states IDLE, ERASE, EXPOSE, SELECT, CONVERT and DONE.
REQ-016 IDLE: frame_start=1 SHALL latch exp_time (0 treated as 1) and move to ERASE next cycle; row index cleared to 0.
REQ-017 ERASE: erase SHALL be 1 for exactly one cycle, then EXPOSE.
REQ-018 EXPOSE: expose SHALL be 1 for exactly the latched exposure count of cycles, via a down-counter, then SELECT.
REQ-019 SELECT: row_en=1 and row_sel=current row for one settle cycle; transition to CONVERT only if the output buffer is empty or out_valid&&out_ready in that cycle, else remain in SELECT.
REQ-020 CONVERT: adc_start SHALL be 1 on the first CONVERT cycle only; row_en stays 1; wait indefinitely for adc_done.
REQ-021 On adc_done: adc_data SHALL be captured into out_data, row into out_row, out_valid set next cycle; last row -> DONE, else row+1 and SELECT.
REQ-022 out_valid SHALL stay 1 with out_data/out_row stable until out_ready=1; cleared the cycle after handshake.
REQ-023 DONE: wait until the output buffer is empty, then pulse frame_done for one cycle and return to IDLE.
REQ-024 frame_start while busy SHALL be ignored; adc_done outside CONVERT SHALL be ignored.
REQ-025 row_en SHALL be 0 in IDLE, ERASE, EXPOSE and DONE; erase and expose never simultaneously 1.

Reset
REQ-026 reset low SHALL immediately force state IDLE, all outputs 0, output buffer empty, counters 0, including mid-frame; no frame_done is issued for an aborted frame.

Structure
REQ-027 SHALL place the state enum and default parameter constants in shared package pixel_seq_pkg.
REQ-028 SHALL instantiate one sub-module exposure_timer (loadable EXP_W down-counter with zero flag).

Verification
REQ-029 exp_time=5, out_ready=1, adc_done 3 cycles after each adc_start, data=row*16+1 -> erase 1 cycle, expose 5 cycles, outputs 0x01,0x11,0x21,0x31 with out_row 0..3, one frame_done.
REQ-030 exp_time=0 -> expose high exactly 1 cycle.
REQ-031 out_ready=0 for 20 cycles after first result -> out_data 0x01 held stable, state held in SELECT for row 1, no adc_start until handshake.
REQ-032 frame_start pulsed during EXPOSE and spurious adc_done during SELECT -> no effect, exactly 4 results.
REQ-033 reset low during CONVERT of row 2 -> all outputs 0 next edge, no frame_done; new frame afterwards starts at row 0.
